// File: rtl/proc_pkg.sv
// proc_pkg: shared types and helpers for the register serial transmitter.
package proc_pkg;
  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_t;
  function automatic int frame_bits(input int data_w, input int parity_en);
    return 2 * data_w + 2 + parity_en;
  endfunction
endpackage

// File: rtl/bit_timer.sv
// bit_timer: down-counter that ticks on the last cycle of each serial bit period.
module bit_timer #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic Clk,
  input  logic Reset,
  input  logic load,
  input  logic en,
  output logic tick
);
  localparam int W = $clog2(CLKS_PER_BIT);
  localparam logic [W-1:0] TOP = W'(CLKS_PER_BIT - 1);
  logic [W-1:0] cnt;
  assign tick = en && (cnt == '0);
  always_ff @(posedge Clk or negedge Reset)
    if (!Reset) cnt <= '0;
    else if (load || tick) cnt <= TOP;
    else if (en) cnt <= cnt - 1'b1;
endmodule

// File: rtl/reg_serial_tx.sv
// reg_serial_tx: sends {B,A} LSB-first as one framed serial stream with optional even parity.
module reg_serial_tx
  import proc_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int DATA_W       = 8,
  parameter int PARITY_EN    = 1
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Start,
  input  logic [DATA_W-1:0] A,
  input  logic [DATA_W-1:0] B,
  output logic              TxD,
  output logic              Busy,
  output logic              Done
);
  localparam int BW = $clog2(2 * DATA_W);
  localparam logic [BW-1:0] LAST = BW'(2 * DATA_W - 1);
  tx_state_t         state;
  logic [2*DATA_W-1:0] sr;
  logic [BW-1:0]     bit_cnt;
  logic              par;
  logic              tick;
  bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
    .Clk  (Clk),
    .Reset(Reset),
    .load (state == TX_IDLE && Start),
    .en   (Busy),
    .tick (tick)
  );
  // TxD is always a registered copy of the bit being sent, loaded one edge ahead
  always_ff @(posedge Clk or negedge Reset)
    if (!Reset) begin
      state   <= TX_IDLE;
      sr      <= '0;
      bit_cnt <= '0;
      par     <= 1'b0;
      TxD     <= 1'b1;
      Busy    <= 1'b0;
      Done    <= 1'b0;
    end else begin
      Done <= 1'b0;
      case (state)
        TX_IDLE: if (Start) begin
          sr    <= {B, A};
          par   <= ^{B, A};
          state <= TX_START;
          TxD   <= 1'b0;
          Busy  <= 1'b1;
        end
        TX_START: if (tick) begin
          state   <= TX_DATA;
          TxD     <= sr[0];
          bit_cnt <= '0;
        end
        TX_DATA: if (tick) begin
          if (bit_cnt == LAST) begin
            state <= (PARITY_EN != 0) ? TX_PARITY : TX_STOP;
            TxD   <= (PARITY_EN != 0) ? par : 1'b1;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
            sr      <= sr >> 1;
            TxD     <= sr[1];
          end
        end
        TX_PARITY: if (tick) begin
          state <= TX_STOP;
          TxD   <= 1'b1;
        end
        TX_STOP: if (tick) begin
          state <= TX_IDLE;
          Busy  <= 1'b0;
          Done  <= 1'b1;
        end
        default: state <= TX_IDLE;
      endcase
    end
endmodule

// File: tb/tb_reg_serial_tx.sv
// tb_reg_serial_tx: directed scoreboard bench for reg_serial_tx, with and without parity.
module tb_reg_serial_tx;
  logic       Clk = 1'b0;
  logic       Reset = 1'b0;
  logic       Start = 1'b0;
  logic [7:0] A = '0;
  logic [7:0] B = '0;
  logic       txd_p, busy_p, done_p;
  logic       txd_n, busy_n, done_n;
  int         vectors = 0;
  int         miscompares = 0;

  always #5 Clk = ~Clk;

  reg_serial_tx #(.CLKS_PER_BIT(4), .DATA_W(8), .PARITY_EN(1)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .A(A), .B(B),
    .TxD(txd_p), .Busy(busy_p), .Done(done_p)
  );
  reg_serial_tx #(.CLKS_PER_BIT(4), .DATA_W(8), .PARITY_EN(0)) dut_np (
    .Clk(Clk), .Reset(Reset), .Start(Start), .A(A), .B(B),
    .TxD(txd_n), .Busy(busy_n), .Done(done_n)
  );

  task automatic check_vec(input string tag, input int cyc, input logic [2:0] obs, input logic [2:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s cycle %0d txd/busy/done got %b expected %b", tag, cyc, obs, exp);
    end
  endtask

  task automatic check_idle(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      @(negedge Clk);
      check_vec(tag, i, {txd_p, busy_p, done_p}, 3'b100);
    end
  endtask

  // Builds the expected per-cycle line image of one frame, then checks it cycle by cycle
  task automatic check_frame(input logic [7:0] a, input logic [7:0] b, input bit np, input string tag);
    logic [2:0]  q[$];
    logic [15:0] d;
    logic [2:0]  obs;
    logic        v;
    int          pe;
    int          nb;
    int          cyc;
    d  = {b, a};
    pe = np ? 0 : 1;
    nb = proc_pkg::frame_bits(8, pe);
    for (int k = 0; k < nb; k++) begin
      if (k == 0) v = 1'b0;
      else if (k <= 16) v = d[k-1];
      else if (pe == 1 && k == 17) v = ^d;
      else v = 1'b1;
      for (int c = 0; c < 4; c++) q.push_back({v, 1'b1, 1'b0});
    end
    q.push_back(3'b101);
    cyc = 0;
    while (q.size() > 0) begin
      @(negedge Clk);
      cyc++;
      obs = np ? {txd_n, busy_n, done_n} : {txd_p, busy_p, done_p};
      check_vec(tag, cyc, obs, q.pop_front());
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge Clk);
    check_idle(2, "reset_hold");
    Reset = 1'b1;
    check_idle(20, "t1_idle");

    A = 8'h5A; B = 8'hC3; Start = 1'b1;
    fork
      check_frame(8'h5A, 8'hC3, 1'b0, "t2_frame");
      begin @(negedge Clk); Start = 1'b0; end
    join
    check_idle(4, "t2_after");

    A = 8'h01; B = 8'h00; Start = 1'b1;
    fork
      check_frame(8'h01, 8'h00, 1'b0, "t3_par");
      check_frame(8'h01, 8'h00, 1'b1, "t3_nopar");
      begin @(negedge Clk); Start = 1'b0; end
    join
    check_idle(4, "t3_after");

    A = 8'h5A; B = 8'hC3; Start = 1'b1;
    fork
      check_frame(8'h5A, 8'hC3, 1'b0, "t4_frame");
      begin
        @(negedge Clk); Start = 1'b0;
        repeat (4) @(negedge Clk);
        A = 8'hFF;
        repeat (5) @(negedge Clk);
        Start = 1'b1;
        @(negedge Clk); Start = 1'b0;
        repeat (29) @(negedge Clk);
        Start = 1'b1;
        @(negedge Clk); Start = 1'b0;
      end
    join
    check_idle(6, "t4_after");

    A = 8'hFF; B = 8'h00; Start = 1'b1;
    check_frame(8'hFF, 8'h00, 1'b0, "t5_first");
    fork
      check_frame(8'hFF, 8'h00, 1'b0, "t5_second");
      begin repeat (3) @(negedge Clk); Start = 1'b0; end
    join
    check_idle(4, "t5_after");

    A = 8'h3C; B = 8'h96; Start = 1'b1;
    @(negedge Clk); Start = 1'b0;
    repeat (28) @(negedge Clk);
    check_vec("t6_busy_before", 29, {1'b0, busy_p, done_p}, 3'b010);
    #2 Reset = 1'b0;
    #1 check_vec("t6_async_abort", 29, {txd_p, busy_p, done_p}, 3'b100);
    check_idle(3, "t6_in_reset");
    Reset = 1'b1;
    check_idle(5, "t6_released");
    A = 8'hA5; B = 8'h0F; Start = 1'b1;
    fork
      check_frame(8'hA5, 8'h0F, 1'b0, "t6_frame_par");
      check_frame(8'hA5, 8'h0F, 1'b1, "t6_frame_nopar");
      begin @(negedge Clk); Start = 1'b0; end
    join
    check_idle(4, "t6_after");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
